// File: rtl/serial_reg_loader_pkg.sv
// rtl/serial_reg_loader_pkg.sv - shared states, constants and divider helper for serial_reg_loader
// Contents: bit_state_t (receiver bit FSM), byte_state_t (address/data pairing),
//           OVERSAMPLE / SAMPLE_MID, calc_div() oversample tick divider.
package serial_reg_loader_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int SAMPLE_MID = 8;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} bit_state_t;
   typedef enum logic {EXPECT_ADDR, EXPECT_DATA} byte_state_t;

   // Clocks per oversample tick, truncated, never below 1.
   function automatic int calc_div(input int clkrate, input int baudrate);
      int d;
      d = clkrate / (baudrate * OVERSAMPLE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/serial_reg_loader_uart_rx_byte.sv
// rtl/serial_reg_loader_uart_rx_byte.sv - 16x oversampled serial byte receiver
// Ports: clk, rst_n (async active-low), rx (idle high)
//        byte_valid / byte_data : one-cycle pulse with the accepted byte
//        byte_err               : one-cycle pulse on bad stop bit (or parity)
//        busy                   : start-bit detect until stop-bit sample
//        tick                   : oversample tick, line_idle : IDLE with rx high
// Macro SERIAL_PARITY_EN selects 8E1 framing; default is 8N1.
module uart_rx_byte
   import serial_reg_loader_pkg::*;
#(
   parameter int CLKRATE  = 3_579_545,
   parameter int BAUDRATE = 9_600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_err,
   output logic       busy,
   output logic       tick,
   output logic       line_idle
);

   localparam int DIV = calc_div(CLKRATE, BAUDRATE);
   localparam int DW  = $clog2(DIV + 1);

   logic [DW-1:0] div_cnt;
   logic          rx_meta;
   logic          rx_s;
   bit_state_t    state;
   logic [3:0]    os_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          brk;
   logic          frame_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign tick = (div_cnt == DW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

`ifdef SERIAL_PARITY_EN
   logic par_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         par_bad <= 1'b0;
      else if (state == PARITY && tick && os_cnt == 4'(OVERSAMPLE - 1))
         par_bad <= (^shift) ^ rx_s;   // even parity
   end

   assign frame_ok = rx_s & ~par_bad;
`else
   assign frame_ok = rx_s;
`endif

   assign line_idle = (state == IDLE) && rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         os_cnt     <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         brk        <= 1'b0;
         busy       <= 1'b0;
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
         byte_data  <= '0;
      end else begin
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state  <= START;
                  os_cnt <= '0;
                  busy   <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (os_cnt == 4'(SAMPLE_MID - 1)) begin
                     os_cnt <= '0;
                     if (rx_s) begin
                        state <= IDLE;   // glitch, not a real start bit
                        busy  <= 1'b0;
                     end else begin
                        state   <= DATA;
                        bit_idx <= '0;
                     end
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (os_cnt == 4'(OVERSAMPLE - 1)) begin
                     os_cnt  <= '0;
                     shift   <= {rx_s, shift[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7) begin
`ifdef SERIAL_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
            end
`ifdef SERIAL_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (os_cnt == 4'(OVERSAMPLE - 1)) begin
                     os_cnt <= '0;
                     state  <= STOP;
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
            end
`endif
            STOP: begin
               if (brk) begin
                  // Hold off until the line returns high so a break cannot retrigger.
                  if (rx_s) begin
                     brk   <= 1'b0;
                     state <= IDLE;
                  end
               end else if (tick) begin
                  if (os_cnt == 4'(OVERSAMPLE - 1)) begin
                     os_cnt <= '0;
                     busy   <= 1'b0;
                     if (frame_ok) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shift;
                        state      <= IDLE;
                     end else begin
                        byte_err <= 1'b1;
                        if (rx_s)
                           state <= IDLE;
                        else
                           brk <= 1'b1;
                     end
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/serial_reg_loader.sv
// rtl/serial_reg_loader.sv - serial (address, data) byte pairs to register-write strobes
// Ports: clk, rst_n (async active-low), rx (serial in, idle high)
//        reg_we / reg_addr / reg_data : one-cycle register write
//        frame_err                    : one-cycle pulse on framing/parity error
//        busy                         : receiver inside a frame
// Macro SERIAL_PARITY_EN selects 8E1 framing in the receiver; default is 8N1.
module serial_reg_loader
   import serial_reg_loader_pkg::*;
#(
   parameter int CLKRATE   = 3_579_545,
   parameter int BAUDRATE  = 9_600,
   parameter int IDLE_BITS = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       reg_we,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_data,
   output logic       frame_err,
   output logic       busy
);

   localparam int TO_LIMIT = IDLE_BITS * OVERSAMPLE;
   localparam int TW       = $clog2(TO_LIMIT + 1);

   logic          byte_valid;
   logic          byte_err;
   logic [7:0]    byte_data;
   logic          tick;
   logic          line_idle;
   byte_state_t   pair_state;
   logic [7:0]    addr_hold;
   logic [TW-1:0] idle_cnt;
   logic          timeout;

   uart_rx_byte #(
      .CLKRATE  (CLKRATE),
      .BAUDRATE (BAUDRATE)
   ) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_err   (byte_err),
      .busy       (busy),
      .tick       (tick),
      .line_idle  (line_idle)
   );

   assign timeout = (idle_cnt == TW'(TO_LIMIT));

   // Saturating idle-line counter; any start bit (line no longer idle) clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idle_cnt <= '0;
      else if (!line_idle)
         idle_cnt <= '0;
      else if (tick && !timeout)
         idle_cnt <= idle_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_state <= EXPECT_ADDR;
         addr_hold  <= '0;
         reg_we     <= 1'b0;
         reg_addr   <= '0;
         reg_data   <= '0;
         frame_err  <= 1'b0;
      end else begin
         reg_we    <= 1'b0;
         frame_err <= 1'b0;
         if (byte_err) begin
            frame_err  <= 1'b1;
            pair_state <= EXPECT_ADDR;
         end else if (byte_valid) begin
            if (pair_state == EXPECT_ADDR) begin
               addr_hold  <= byte_data;
               pair_state <= EXPECT_DATA;
            end else begin
               reg_we     <= 1'b1;
               reg_addr   <= addr_hold;
               reg_data   <= byte_data;
               pair_state <= EXPECT_ADDR;
            end
         end else if (timeout && pair_state == EXPECT_DATA) begin
            pair_state <= EXPECT_ADDR;   // drop the stale address silently
         end
      end
   end

endmodule

// File: tb/tb_serial_reg_loader.sv
// tb/tb_serial_reg_loader.sv - table-driven bench for serial_reg_loader
module tb_serial_reg_loader;

`ifdef SERIAL_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int LAT = 12 + 16 * (NB - 1);

   typedef struct {
      int              nb;
      logic [0:3][7:0] b;
      logic [0:3]      bad_stop;
      logic [0:3]      bad_par;
      int              gap;
      int              n_wr;
      logic [0:1][15:0] wr;
      int              n_err;
      int              lat_idx;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       reg_we;
   logic [7:0] reg_addr;
   logic [7:0] reg_data;
   logic       frame_err;
   logic       busy;

   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   logic [15:0] wq[$];
   int         wc[$];
   int         errs = 0;
   int         overlap = 0;
   int         busy_cnt = 0;
   vec_t       vq[$];

   serial_reg_loader #(
      .CLKRATE   (1_600_000),
      .BAUDRATE  (100_000),
      .IDLE_BITS (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_data  (reg_data),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reg_we) begin
         wq.push_back({reg_addr, reg_data});
         wc.push_back(cyc);
      end
      if (frame_err) errs++;
      if (reg_we && frame_err) overlap++;
      if (busy) busy_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_stop, input logic bad_par,
                            input int cut, output int start);
      logic [10:0] fr;
      start = cyc;
`ifdef SERIAL_PARITY_EN
      fr = {~bad_stop, (^b) ^ bad_par, b, 1'b0};
`else
      fr = {bad_par, ~bad_stop, b, 1'b0};
`endif
      for (int i = 0; i < cut; i++) begin
         rx = fr[i];
         repeat (16) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * 16) @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t        v;
      int          st[4];
      int          s;
      int          lat;
      logic [15:0] got;

      vq.push_back(vec_t'{2, {8'h05, 8'hA3, 8'h00, 8'h00}, 4'b0000, 4'b0000, 0,  1, {16'h05A3, 16'h0000}, 0, 1});
      vq.push_back(vec_t'{4, {8'h01, 8'h11, 8'h02, 8'h22}, 4'b0000, 4'b0000, 0,  2, {16'h0111, 16'h0222}, 0, 1});
      vq.push_back(vec_t'{3, {8'h07, 8'h03, 8'h44, 8'h00}, 4'b1000, 4'b0000, 2,  1, {16'h0344, 16'h0000}, 1, 2});
      vq.push_back(vec_t'{3, {8'h09, 8'h0A, 8'h55, 8'h00}, 4'b0000, 4'b0000, 25, 1, {16'h0A55, 16'h0000}, 0, 2});
      vq.push_back(vec_t'{2, {8'h5A, 8'hC3, 8'h00, 8'h00}, 4'b0000, 4'b0000, 18, 1, {16'h5AC3, 16'h0000}, 0, 1});
      vq.push_back(vec_t'{3, {8'h12, 8'h34, 8'h56, 8'h00}, 4'b0000, 4'b0000, 22, 1, {16'h3456, 16'h0000}, 0, 2});
`ifdef SERIAL_PARITY_EN
      vq.push_back(vec_t'{4, {8'h04, 8'h31, 8'h68, 8'h79}, 4'b0000, 4'b0100, 0,  1, {16'h6879, 16'h0000}, 1, 3});
`endif

      // reset state
      repeat (4) @(posedge clk);
      #1;
      check("rst_reg_we", reg_we, 0);
      check("rst_reg_addr", reg_addr, 0);
      check("rst_reg_data", reg_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      idle_bits(2);

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         wq.delete();
         wc.delete();
         errs = 0;
         for (int j = 0; j < v.nb; j++) begin
            send_byte(v.b[j], v.bad_stop[j], v.bad_par[j], NB, st[j]);
            if (j == 0) idle_bits(v.gap);
         end
         idle_bits(3);
         check($sformatf("v%0d_n_writes", i), wq.size(), v.n_wr);
         for (int k = 0; k < v.n_wr; k++) begin
            got = (k < wq.size()) ? wq[k] : 16'hxxxx;
            check($sformatf("v%0d_write%0d_addr_data", i, k), got, v.wr[k]);
         end
         check($sformatf("v%0d_n_frame_err", i), errs, v.n_err);
         if (v.n_wr > 0) begin
            lat = (wc.size() > 0) ? wc[0] - st[v.lat_idx] : -1;
            check($sformatf("v%0d_write_latency", i), lat, LAT);
         end
      end

      // 4-clock low glitch on an idle line
      wq.delete();
      errs = 0;
      busy_cnt = 0;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle_bits(3);
      check("glitch_writes", wq.size(), 0);
      check("glitch_frame_err", errs, 0);
      check("glitch_busy_short", (busy_cnt >= 1 && busy_cnt <= 16), 1);
      check("glitch_busy_end", busy, 0);

      // reset asserted during the data byte of a pair
      send_byte(8'h66, 1'b0, 1'b0, NB, s);
      send_byte(8'h77, 1'b0, 1'b0, 4, s);
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_reg_we", reg_we, 0);
      check("midrst_reg_addr", reg_addr, 0);
      check("midrst_reg_data", reg_data, 0);
      check("midrst_frame_err", frame_err, 0);
      check("midrst_busy", busy, 0);
      rst_n = 1'b1;
      idle_bits(2);
      wq.delete();
      errs = 0;
      send_byte(8'h21, 1'b0, 1'b0, NB, s);
      send_byte(8'h43, 1'b0, 1'b0, NB, s);
      idle_bits(3);
      check("postrst_n_writes", wq.size(), 1);
      got = (wq.size() > 0) ? wq[0] : 16'hxxxx;
      check("postrst_addr_data", got, 16'h2143);
      check("postrst_frame_err", errs, 0);

      check("we_err_overlap", overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_reg_loader.md
Name: serial_reg_loader

Overview:
- Upstream stage of the chiptune core.
- Receives asynchronous 8N1 serial bytes on a single pin, oversampled 16x in the system clock domain.
- Groups received bytes into (address, data) pairs and issues one-cycle register-write strobes into the chiptune register file.
- An idle-gap timeout re-aligns pairing so a host can always recover byte framing.

Parameters:
- CLKRATE, 3_579_545: system clock frequency in Hz.
- BAUDRATE, 9_600: serial bit rate in bits/s.
- IDLE_BITS, 20: idle-line length in bit times that forces the next byte to be treated as an address.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  asynchronous serial data, idle high
- reg_we  output  1  one-cycle write strobe
- reg_addr  output  8  register address, valid when reg_we=1
- reg_data  output  8  register data, valid when reg_we=1
- frame_err  output  1  one-cycle pulse on framing/parity error
- busy  output  1  high from start-bit detect to end of stop-bit sample

Behaviour:
- Interface: one clock, clk. Reset is rst_n: asynchronous, active-low.
- Reset values: reg_we=0, reg_addr=0, reg_data=0, frame_err=0, busy=0. Internal state returns to IDLE / EXPECT_ADDR. Reset mid-byte discards the partial byte and any held address.
- Sampling:
  - rx passes through a 2-FF synchronizer (reset to 1) before any use.
  - Oversample tick divider = CLKRATE/(BAUDRATE*16), integer-truncated, minimum 1. Divider counter width = $clog2(divider+1).
- Bit FSM states:
  - IDLE: synchronized rx falling edge → START; sample counter cleared.
  - START: at tick 8, rx=1 is a glitch → IDLE (no error); rx=0 → DATA.
  - DATA: 8 bits, LSB first, sampled every 16 ticks at bit centre.
  - STOP: sampled 16 ticks after the last data bit. rx=1 → byte accepted. rx=0 → frame_err pulse, byte dropped, byte FSM forced to EXPECT_ADDR. The FSM then waits for rx high before returning to IDLE, so a break does not retrigger.
- Byte FSM:
  - EXPECT_ADDR: an accepted byte is latched as the address → EXPECT_DATA.
  - EXPECT_DATA: an accepted byte drives reg_addr/reg_data with reg_we=1 on the clock after the stop-bit sample → EXPECT_ADDR.
- Latency: reg_we rises exactly 1 clk after the stop-bit centre sample of the data byte. reg_addr/reg_data hold their values until the next write.
- Idle timeout:
  - Counter counts ticks while the bit FSM is IDLE and rx=1; it saturates and is cleared by any start bit.
  - Reaching IDLE_BITS*16 ticks in EXPECT_DATA forces EXPECT_ADDR. The held address is discarded and no error is reported.
- Back-to-back bytes (stop bit directly followed by start bit) are accepted with no lost bytes.
- A write strobe and an error pulse never occur in the same cycle.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- When defined:
  - Frame becomes 8E1; a PARITY state is inserted between DATA and STOP.
  - A parity mismatch is handled exactly like a stop-bit error: frame_err pulse at stop-bit time, byte dropped, EXPECT_ADDR.
- When undefined: 8N1, no PARITY state, no parity logic synthesized.

Decomposition:
- Shared package holds:
  - bit-state enum (IDLE, START, DATA, PARITY, STOP);
  - byte-state enum (EXPECT_ADDR, EXPECT_DATA);
  - OVERSAMPLE=16, SAMPLE_MID=8.
- One natural sub-module: uart_rx_byte (synchronizer, tick divider, bit FSM; outputs byte_valid, byte, byte_err).
- Pairing and timeout logic stays in the top of the block.

Test Plan:
- Bench settings: CLKRATE=1_600_000, BAUDRATE=100_000 (divider 1, 16 clk per bit), IDLE_BITS=20.
- Send 0x05 then 0xA3 → exactly one reg_we pulse, reg_addr=0x05, reg_data=0xA3, 1 clk after the second stop-bit centre.
- Send 0x01,0x11,0x02,0x22 back-to-back with no gaps → two writes: (0x01,0x11) then (0x02,0x22); frame_err never asserted.
- Send 0x07 with stop bit driven 0 → frame_err single pulse, no reg_we. Then send 0x03,0x44 → write (0x03,0x44).
- Send 0x09, idle 25 bit times, then send 0x0A,0x55 → single write (0x0A,0x55); 0x09 discarded.
- Drive rx low for 4 clk only → no busy past START, no frame_err, no write. Assert rst_n low during the data byte of a pair → outputs zero, and the next pair writes correctly.
- With SERIAL_PARITY_EN: send 0x04 with correct parity, then 0x31 with wrong parity → frame_err, no write.
